// File: rtl/bsg_credit_flow_sender.sv
// Sender side of a credit-based link: registers accepted words onto a no-backpressure link
// and tracks in-flight words against a fixed credit budget.
// Optional feature macro: BSG_CREDIT_SENDER_BYPASS_EN (same-cycle credit reuse at full budget).
module bsg_credit_flow_sender #(
    parameter int  width_p      = 32,
    parameter int  credit_max_p = 9,
    localparam int cnt_width_lp = $clog2(credit_max_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [width_p-1:0]      data_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic [width_p-1:0]      data_o,
    output logic                    v_o,
    input  logic                    credit_i,
    output logic [cnt_width_lp-1:0] outstanding_o,
    output logic                    up_o,
    output logic                    down_o,
    output logic                    error_o
);

    localparam logic [cnt_width_lp-1:0] credit_max_lp = cnt_width_lp'(credit_max_p);
    localparam logic [cnt_width_lp-1:0] cnt_one_lp    = cnt_width_lp'(32'd1);
    localparam logic [cnt_width_lp-1:0] cnt_zero_lp   = {cnt_width_lp{1'b0}};

    logic [cnt_width_lp-1:0] outstanding_r;
    logic [cnt_width_lp-1:0] cnt_next_s;
    logic [width_p-1:0]      data_r;
    logic                    v_r;
    logic                    error_r;

    logic                    credit_avail_s;
    logic                    ready_s;
    logic                    accept_s;
    logic                    down_s;
    logic                    underflow_s;

    assign credit_avail_s = (outstanding_r < credit_max_lp);

`ifdef BSG_CREDIT_SENDER_BYPASS_EN
    // A credit arriving this cycle frees a slot immediately, so the link can run at full rate at max budget.
    assign ready_s = credit_avail_s | credit_i;
`else
    assign ready_s = credit_avail_s;
`endif

    assign accept_s    = v_i & ready_s;
    assign down_s      = credit_i & (outstanding_r != cnt_zero_lp);
    assign underflow_s = credit_i & (outstanding_r == cnt_zero_lp);

    // Occupancy next-state: simultaneous send and credit return cancel out.
    always_comb begin
        cnt_next_s = outstanding_r;
        case ({accept_s, down_s})
            2'b10:   cnt_next_s = outstanding_r + cnt_one_lp;
            2'b01:   cnt_next_s = outstanding_r - cnt_one_lp;
            default: cnt_next_s = outstanding_r;
        endcase
    end

    // Link register, occupancy counter and sticky underflow flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            outstanding_r <= cnt_zero_lp;
            data_r        <= {width_p{1'b0}};
            v_r           <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            outstanding_r <= cnt_next_s;
            v_r           <= accept_s;
            if (accept_s) begin
                data_r <= data_i;
            end else begin
                data_r <= data_r;
            end
            error_r       <= error_r | underflow_s;
        end
    end

    assign ready_o       = ready_s;
    assign data_o        = data_r;
    assign v_o           = v_r;
    assign outstanding_o = outstanding_r;
    assign up_o          = accept_s;
    assign down_o        = down_s;
    assign error_o       = error_r;

endmodule

// File: tb/tb_bsg_credit_flow_sender.sv
// Self-checking bench for bsg_credit_flow_sender: directed steps plus a random phase,
// with a data scoreboard and an independent occupancy model.
module tb_bsg_credit_flow_sender;

    localparam int W   = 32;
    localparam int MAX = 9;
    localparam int CW  = 4;

    logic          clk;
    logic          reset_n_i;
    logic [W-1:0]  data_i;
    logic          v_i;
    logic          ready_o;
    logic [W-1:0]  data_o;
    logic          v_o;
    logic          credit_i;
    logic [CW-1:0] outstanding_o;
    logic          up_o;
    logic          down_o;
    logic          error_o;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] sb_q[$];
    int           m_cnt;
    bit           m_err;
    int           ext_cnt;
    int           vo_pulses;
    int           down_pulses;
    logic [W-1:0] seq;

    bsg_credit_flow_sender #(.width_p(W), .credit_max_p(MAX)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n_i),
        .data_i       (data_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .v_o          (v_o),
        .credit_i     (credit_i),
        .outstanding_o(outstanding_o),
        .up_o         (up_o),
        .down_o       (down_o),
        .error_o      (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: asynchronous reset is checked before any further clock edge.
    task automatic do_reset();
        v_i       = 1'b0;
        credit_i  = 1'b0;
        reset_n_i = 1'b0;
        #1;
        chk("rst_v_o", {31'd0, v_o}, 32'd0);
        chk("rst_data_o", data_o, 32'd0);
        chk("rst_outstanding", {28'd0, outstanding_o}, 32'd0);
        chk("rst_error", {31'd0, error_o}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n_i = 1'b1;
        @(posedge clk);
        #1;
        sb_q.delete();
        m_cnt   = 0;
        m_err   = 1'b0;
        ext_cnt = 0;
    endtask

    // One clock cycle of stimulus with full checking against the model and scoreboard.
    task automatic cycle(input logic v, input logic c);
        logic exp_ready;
        logic exp_acc;
        logic exp_down;
        logic [W-1:0] d;
        logic [W-1:0] exp_d;
        d        = seq;
        v_i      = v;
        data_i   = d;
        credit_i = c;
        @(negedge clk);
        exp_ready = (m_cnt < MAX);
`ifdef BSG_CREDIT_SENDER_BYPASS_EN
        exp_ready = exp_ready | c;
`endif
        exp_acc  = v & exp_ready;
        exp_down = c & (m_cnt != 0);
        chk("ready_o", {31'd0, ready_o}, {31'd0, exp_ready});
        chk("up_o", {31'd0, up_o}, {31'd0, exp_acc});
        chk("down_o", {31'd0, down_o}, {31'd0, exp_down});
        ext_cnt = ext_cnt + int'(up_o) - int'(down_o);
        if (down_o === 1'b1) down_pulses++;
        if (exp_acc) begin
            sb_q.push_back(d);
            seq = seq + 32'd1;
        end
        m_cnt = m_cnt + int'(exp_acc) - int'(exp_down);
        m_err = m_err | (c & (m_cnt == 0) & ~exp_down & ~exp_acc) | (c & ~exp_down);
        @(posedge clk);
        #1;
        chk("outstanding_o", {28'd0, outstanding_o}, m_cnt);
        chk("ext_counter", {28'd0, outstanding_o}, ext_cnt);
        chk("error_o", {31'd0, error_o}, {31'd0, m_err});
        chk("v_o", {31'd0, v_o}, {31'd0, exp_acc});
        if (v_o === 1'b1) begin
            vo_pulses++;
            if (sb_q.size() == 0) begin
                chk("sb_underrun", 32'd1, 32'd0);
            end else begin
                exp_d = sb_q.pop_front();
                chk("data_o", data_o, exp_d);
            end
        end
    endtask

    initial begin
        reset_n_i = 1'b0;
        v_i       = 1'b0;
        credit_i  = 1'b0;
        data_i    = '0;
        seq       = 32'hA000_0001;
        vo_pulses = 0;
        down_pulses = 0;
        m_cnt = 0; m_err = 1'b0; ext_cnt = 0;
        @(posedge clk);
        #1;
        do_reset();

        // 1: async reset mid-stream with v_o=1, outstanding=5
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
        chk("pre_rst_cnt5", {28'd0, outstanding_o}, 32'd5);
        chk("pre_rst_v_o", {31'd0, v_o}, 32'd1);
        do_reset();

        // 2: fill with no credits
        vo_pulses = 0;
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0);
        chk("fill_pulses", vo_pulses, 32'd9);
        chk("fill_cnt", {28'd0, outstanding_o}, 32'd9);
        chk("fill_sb_empty", sb_q.size(), 32'd0);

        // 3: drain with credits only
        down_pulses = 0;
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1);
        chk("drain_downs", down_pulses, 32'd9);
        chk("drain_cnt", {28'd0, outstanding_o}, 32'd0);
        chk("drain_err", {31'd0, error_o}, 32'd0);

        // 4: simultaneous send and credit at full
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
`ifdef BSG_CREDIT_SENDER_BYPASS_EN
        chk("simul_cnt", {28'd0, outstanding_o}, 32'd9);
        chk("simul_v_o", {31'd0, v_o}, 32'd1);
`else
        chk("simul_cnt", {28'd0, outstanding_o}, 32'd8);
        chk("simul_v_o", {31'd0, v_o}, 32'd0);
`endif
        cycle(1'b1, 1'b0);
        chk("simul_next_cnt", {28'd0, outstanding_o}, 32'd9);

        // 5: spurious credit at zero
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1);
        chk("spur_pre_cnt", {28'd0, outstanding_o}, 32'd0);
        cycle(1'b0, 1'b1);
        chk("spur_cnt", {28'd0, outstanding_o}, 32'd0);
        chk("spur_err", {31'd0, error_o}, 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
        chk("spur_sticky", {31'd0, error_o}, 32'd1);
        do_reset();
        chk("spur_cleared", {31'd0, error_o}, 32'd0);

        // 6: random traffic, credits never exceed words sent
        for (int i = 0; i < 10000; i++) begin
            logic rv;
            logic rc;
            rv = 1'($urandom_range(0, 3) != 0);
            rc = 1'($urandom_range(0, 2) != 0) & (m_cnt != 0);
            cycle(rv, rc);
        end
        for (int i = 0; i < 12 && m_cnt != 0; i++) cycle(1'b0, 1'b1);
        chk("rand_drained", {28'd0, outstanding_o}, 32'd0);
        chk("rand_sb_empty", sb_q.size(), 32'd0);
        chk("rand_no_err", {31'd0, error_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
